alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control-unit counterpart to the 10-bit processor's multi-state ALU and register file.
- Accepts one 10-bit instruction per EXEC handshake and drives the ALU control strobes (Ain, Gin, Gout, FN).
- Also drives the per-register Rin/Rout enables and the external-data enable, stepping through T1..T4 on the shared bus clock.
- Reports completion with a one-cycle Done pulse.

Parameters:
- OPC_W, 4, opcode field width (INSTR[9:6]); also the width of the FN output.
- RSEL_W, 3, register-select field width; 2**RSEL_W = 8 one-hot register enables.

Ports:
- CLKb  input  1  system clock; all state updates on the falling edge.
- RSTb  input  1  asynchronous active-low reset.
- EXEC  input  1  start request; sampled only in IDLE.
- INSTR  input  10  instruction: [9:6] opcode, [5:3] Rx, [2:0] Ry.
- Rin  output  8  one-hot register load enables.
- Rout  output  8  one-hot register bus-drive enables.
- Ain  output  1  ALU A/operate strobe.
- Gin  output  1  ALU result-register load.
- Gout  output  1  ALU result bus drive.
- FN  output  4  ALU function: 0001 ADD, 0010 SUB, 0100 AND, 1000 OR, 0000 pass/load-A.
- EXTRN  output  1  external data drives the bus.
- Busy  output  1  high in any state except IDLE.
- Done  output  1  one-cycle completion pulse.
- Illegal  output  1  one-cycle pulse with Done for an undefined opcode.

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-low (RSTb), clock is CLKb.
  - Reset forces state=IDLE and IR=0.
  - All outputs are 0 immediately when RSTb is low, including mid-instruction; the partial operation is abandoned.
- State register: IDLE, T1, T2, T3, T4. IR holds the instruction latched at acceptance.
- Acceptance: in IDLE, if EXEC=1 at a falling edge, latch IR<=INSTR and go to T1. EXEC is ignored in all other states.
- Outputs are decoded combinationally from state and IR. In IDLE all outputs are 0, and no bus enable is ever asserted outside T1..T4.
- Opcodes (IR[9:6]):
  - 0000 LOAD: T1: EXTRN=1, Rin[Rx]=1, Done=1.
  - 0001 MOV: T1: Rout[Ry]=1, Rin[Rx]=1, Done=1.
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR (Rx <= Rx op Ry):
    - T1: Rout[Rx]=1, Ain=1, FN=0000 (load operand A).
    - T2: Rout[Ry]=1, Ain=1, FN=op code per the FN port list.
    - T3: Gin=1.
    - T4: Gout=1, Rin[Rx]=1, Done=1.
  - 0110..1111: T1: Done=1, Illegal=1; no bus or ALU strobes.
- Transitions:
  - Single-step instructions go T1->IDLE.
  - ALU instructions go T1->T2->T3->T4->IDLE.
- Latency: Done asserts 1 cycle (LOAD/MOV/illegal) or 4 cycles (ALU ops) after the accepting edge.
- Throughput: IDLE always lasts at least one cycle. EXEC held high during Done is not accepted until the edge after IDLE is entered. Minimum issue interval is 2 cycles (single-step) or 5 cycles (ALU op).
- Rx==Ry is legal:
  - MOV Rx,Rx asserts Rin and Rout of the same register.
  - ALU ops use Rx for both operands.
- INSTR changes after acceptance have no effect until the next acceptance.
- Mutual exclusion: at most one of {any Rout bit, Gout, EXTRN} is high in any cycle. Rin and Rout are each one-hot or zero.

Test Plan:
- Reset mid-op: accept ADD, pull RSTb low during T2 -> all outputs 0 at once; after release, state is IDLE with Busy=0.
- LOAD: EXEC=1, INSTR=10'b0000_101_000 -> next cycle EXTRN=1, Rin=8'b0010_0000, Done=1; then IDLE.
- MOV: INSTR=10'b0001_010_110 -> one cycle with Rout=8'b0100_0000, Rin=8'b0000_0100, Done=1.
- ADD R1,R3 (INSTR=10'b0010_001_011):
  - T1: Rout=8'h02, Ain=1, FN=0000.
  - T2: Rout=8'h08, Ain=1, FN=0001.
  - T3: Gin=1.
  - T4: Gout=1, Rin=8'h02, Done=1.
- Interference and back-to-back: EXEC toggled and INSTR changed during T2..T4 of SUB -> sequence unchanged. EXEC held high throughout -> the next instruction's T1 begins exactly one IDLE cycle after Done.
- Illegal 1010 -> Done=1, Illegal=1 for one cycle, with Rin/Rout/Ain/Gin/Gout/EXTRN all 0. Also run OR with Rx=Ry=7: Rout=8'h80 in both T1 and T2, FN=1000 in T2.

Source files
------------

// File: rtl/alu_sequencer.sv
// Control sequencer for the multi-state ALU datapath: latches one instruction per
// EXEC handshake and steps T1..T4 on the falling clock edge, decoding bus/ALU strobes.
module alu_sequencer #(
    parameter int OPC_W  = 4,
    parameter int RSEL_W = 3
) (
    input  logic                          CLKb,
    input  logic                          RSTb,
    input  logic                          EXEC,
    input  logic [OPC_W+2*RSEL_W-1:0]     INSTR,
    output logic [2**RSEL_W-1:0]          Rin,
    output logic [2**RSEL_W-1:0]          Rout,
    output logic                          Ain,
    output logic                          Gin,
    output logic                          Gout,
    output logic [OPC_W-1:0]              FN,
    output logic                          EXTRN,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Illegal
);

    localparam int IW = OPC_W + 2 * RSEL_W;
    localparam int NR = 2 ** RSEL_W;

    localparam logic [OPC_W-1:0] OP_LOAD = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4
    } state_t;

    state_t            state;
    logic [IW-1:0]     ir;
    logic [OPC_W-1:0]  opc;
    logic [RSEL_W-1:0] rx;
    logic [RSEL_W-1:0] ry;
    logic              is_alu;
    logic [OPC_W-1:0]  alu_fn;

    assign opc = ir[IW-1 -: OPC_W];
    assign rx  = ir[2*RSEL_W-1 -: RSEL_W];
    assign ry  = ir[RSEL_W-1:0];

    function automatic logic [NR-1:0] sel(input logic [RSEL_W-1:0] r);
        sel    = '0;
        sel[r] = 1'b1;
    endfunction

    always_comb begin
        is_alu = 1'b1;
        alu_fn = '0;
        case (opc)
            OP_ADD:  alu_fn = OPC_W'(4'b0001);
            OP_SUB:  alu_fn = OPC_W'(4'b0010);
            OP_AND:  alu_fn = OPC_W'(4'b0100);
            OP_OR:   alu_fn = OPC_W'(4'b1000);
            default: is_alu = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: if (EXEC) begin
                    ir    <= INSTR;
                    state <= S_T1;
                end
                S_T1:    state <= is_alu ? S_T2 : S_IDLE;
                S_T2:    state <= S_T3;
                S_T3:    state <= S_T4;
                S_T4:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Decode from state and IR only; the async reset forces IDLE, so every
    // strobe drops the moment RSTb goes low.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        Rin     = '0;
        Rout    = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        FN      = '0;
        EXTRN   = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        Busy    = (state != S_IDLE);
        case (state)
            S_T1: begin
                if (is_alu) begin
                    Rout = sel(rx);
                    Ain  = 1'b1;
                end else if (opc == OP_LOAD) begin
                    EXTRN = 1'b1;
                    Rin   = sel(rx);
                    Done  = 1'b1;
                end else if (opc == OP_MOV) begin
                    Rout = sel(ry);
                    Rin  = sel(rx);
                    Done = 1'b1;
                end else begin
                    Done    = 1'b1;
                    Illegal = 1'b1;
                end
            end
            S_T2: begin
                Rout = sel(ry);
                Ain  = 1'b1;
                FN   = alu_fn;
            end
            S_T3: Gin = 1'b1;
            S_T4: begin
                Gout = 1'b1;
                Rin  = sel(rx);
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: expected output vectors are queued as each
// instruction is issued and compared one per cycle on the rising (inactive) edge.
module tb_alu_sequencer;

    logic       CLKb  = 1'b1;
    logic       RSTb  = 1'b0;
    logic       EXEC  = 1'b0;
    logic [9:0] INSTR = '0;
    logic [7:0] Rin, Rout;
    logic       Ain, Gin, Gout, EXTRN, Busy, Done, Illegal;
    logic [3:0] FN;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] fn;
        logic       extrn;
        logic       busy;
        logic       done;
        logic       illegal;
    } exp_t;

    exp_t sb[$];
    exp_t obs;
    int   n_cmp = 0;
    int   n_bad = 0;

    assign obs = {Rin, Rout, Ain, Gin, Gout, FN, EXTRN, Busy, Done, Illegal};

    alu_sequencer #(.OPC_W(4), .RSEL_W(3)) dut (
        .CLKb(CLKb), .RSTb(RSTb), .EXEC(EXEC), .INSTR(INSTR),
        .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
        .FN(FN), .EXTRN(EXTRN), .Busy(Busy), .Done(Done), .Illegal(Illegal)
    );

    always #5 CLKb = ~CLKb;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Busy active-cycle vector; idle is all zero.
    function automatic exp_t v(input logic [7:0] rin, input logic [7:0] rout,
                               input logic ain, input logic gin, input logic gout,
                               input logic [3:0] fn, input logic extrn,
                               input logic done, input logic ill);
        v = '{rin: rin, rout: rout, ain: ain, gin: gin, gout: gout, fn: fn,
              extrn: extrn, busy: 1'b1, done: done, illegal: ill};
    endfunction

    // Reference model of one ALU instruction followed by its mandatory idle cycle.
    function automatic void push_alu(input logic [9:0] ins);
        logic [7:0] mx, my;
        logic [3:0] f;
        mx = 8'h01 << ins[5:3];
        my = 8'h01 << ins[2:0];
        case (ins[9:6])
            4'd2:    f = 4'b0001;
            4'd3:    f = 4'b0010;
            4'd4:    f = 4'b0100;
            default: f = 4'b1000;
        endcase
        sb.push_back(v(8'h00, mx, 1, 0, 0, 4'b0000, 0, 0, 0));
        sb.push_back(v(8'h00, my, 1, 0, 0, f, 0, 0, 0));
        sb.push_back(v(8'h00, 8'h00, 0, 1, 0, 4'b0000, 0, 0, 0));
        sb.push_back(v(mx, 8'h00, 0, 0, 1, 4'b0000, 0, 1, 0));
        sb.push_back('0);
    endfunction

    task automatic step(input string tag);
        exp_t e;
        int   drv;
        @(negedge CLKb);
        @(posedge CLKb);
        e = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
        check(tag, 32'(obs), 32'(e));
        drv = int'(Rout != '0) + int'(Gout) + int'(EXTRN);
        check({tag, "/bus_excl"}, 32'(drv <= 1), 32'd1);
        check({tag, "/onehot"}, 32'($onehot0(Rin) && $onehot0(Rout)), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge CLKb);
        check("reset_outputs", 32'(obs), 32'd0);
        #1 RSTb = 1'b1;

        // LOAD R5
        EXEC = 1'b1; INSTR = 10'b0000_101_000;
        sb.push_back(v(8'b0010_0000, 8'h00, 0, 0, 0, 4'b0000, 1, 1, 0));
        sb.push_back('0);
        step("load_t1");
        EXEC = 1'b0;
        step("load_idle");

        // MOV R2,R6
        EXEC = 1'b1; INSTR = 10'b0001_010_110;
        sb.push_back(v(8'b0000_0100, 8'b0100_0000, 0, 0, 0, 4'b0000, 0, 1, 0));
        sb.push_back('0);
        step("mov_t1");
        EXEC = 1'b0;
        step("mov_idle");

        // ADD R1,R3 with literal expectations
        EXEC = 1'b1; INSTR = 10'b0010_001_011;
        sb.push_back(v(8'h00, 8'h02, 1, 0, 0, 4'b0000, 0, 0, 0));
        sb.push_back(v(8'h00, 8'h08, 1, 0, 0, 4'b0001, 0, 0, 0));
        sb.push_back(v(8'h00, 8'h00, 0, 1, 0, 4'b0000, 0, 0, 0));
        sb.push_back(v(8'h02, 8'h00, 0, 0, 1, 4'b0000, 0, 1, 0));
        sb.push_back('0);
        step("add_t1");
        EXEC = 1'b0;
        step("add_t2");
        step("add_t3");
        step("add_t4");
        step("add_idle");

        // SUB R2,R4 with EXEC/INSTR disturbed after acceptance
        EXEC = 1'b1; INSTR = 10'b0011_010_100;
        push_alu(10'b0011_010_100);
        step("sub_t1");
        EXEC = 1'b0;
        step("sub_t2");
        EXEC = 1'b1; INSTR = 10'b0000_111_111;
        step("sub_t3");
        EXEC = 1'b0; INSTR = 10'b1111_000_000;
        step("sub_t4");
        step("sub_idle");

        // Illegal opcode 1010
        EXEC = 1'b1; INSTR = 10'b1010_011_101;
        sb.push_back(v(8'h00, 8'h00, 0, 0, 0, 4'b0000, 0, 1, 1));
        sb.push_back('0);
        step("ill_t1");
        EXEC = 1'b0;
        step("ill_idle");

        // OR R7,R7
        EXEC = 1'b1; INSTR = 10'b0101_111_111;
        sb.push_back(v(8'h00, 8'h80, 1, 0, 0, 4'b0000, 0, 0, 0));
        sb.push_back(v(8'h00, 8'h80, 1, 0, 0, 4'b1000, 0, 0, 0));
        sb.push_back(v(8'h00, 8'h00, 0, 1, 0, 4'b0000, 0, 0, 0));
        sb.push_back(v(8'h80, 8'h00, 0, 0, 1, 4'b0000, 0, 1, 0));
        sb.push_back('0);
        step("or_t1");
        EXEC = 1'b0;
        step("or_t2");
        step("or_t3");
        step("or_t4");
        step("or_idle");

        // Back-to-back with EXEC held high: LOAD R5, MOV R3,R3, AND R6,R0
        EXEC = 1'b1; INSTR = 10'b0000_101_000;
        sb.push_back(v(8'h20, 8'h00, 0, 0, 0, 4'b0000, 1, 1, 0));
        sb.push_back('0);
        sb.push_back(v(8'h08, 8'h08, 0, 0, 0, 4'b0000, 0, 1, 0));
        sb.push_back('0);
        push_alu(10'b0100_110_000);
        step("b2b_load_t1");
        INSTR = 10'b0001_011_011;
        step("b2b_idle0");
        step("b2b_mov_t1");
        INSTR = 10'b0100_110_000;
        step("b2b_idle1");
        step("b2b_and_t1");
        EXEC = 1'b0;
        step("b2b_and_t2");
        step("b2b_and_t3");
        step("b2b_and_t4");
        step("b2b_idle2");

        // Reset in the middle of ADD (during T2)
        EXEC = 1'b1; INSTR = 10'b0010_001_011;
        sb.push_back(v(8'h00, 8'h02, 1, 0, 0, 4'b0000, 0, 0, 0));
        sb.push_back(v(8'h00, 8'h08, 1, 0, 0, 4'b0001, 0, 0, 0));
        step("rst_add_t1");
        EXEC = 1'b0;
        step("rst_add_t2");
        #1 RSTb = 1'b0;
        #1 check("rst_mid_outputs", 32'(obs), 32'd0);
        sb.delete();
        #1 RSTb = 1'b1;
        step("post_rst_idle");
        check("post_rst_busy", 32'(Busy), 32'd0);

        // Sequencer still works after the abandoned op
        EXEC = 1'b1; INSTR = 10'b0000_010_000;
        sb.push_back(v(8'h04, 8'h00, 0, 0, 0, 4'b0000, 1, 1, 0));
        sb.push_back('0);
        step("post_rst_load");
        EXEC = 1'b0;
        step("post_rst_load_idle");

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
